// File: rtl/niosii_subsys_irq_aggregator.sv
// Interrupt aggregator: captures edge/level requests into PENDING, masks them and
// drives one registered irq to the CPU, with a 16-bit Avalon-MM register window.
module niosii_subsys_irq_aggregator #(
    parameter int unsigned NUM_IRQ      = 8,
    parameter logic [15:0] EDGE_DEFAULT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam int N = int'(NUM_IRQ);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] ADDR_MODE    = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;

    // State
    logic [N-1:0] r_pending;
    logic [N-1:0] r_forced;
    logic [N-1:0] r_mask;
    logic [N-1:0] r_mode;
    logic [N-1:0] r_irq_prev;
    logic [15:0]  r_readdata;
    logic         r_irq_out;

    // Next-state and decode
    logic         w_wr;
    logic [N-1:0] w_wdata;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_frc;
    logic [N-1:0] w_event;
    logic [N-1:0] w_forced_nxt;
    logic [N-1:0] w_pend_edge;
    logic [N-1:0] w_pend_level;
    logic [N-1:0] w_pend_nxt;
    logic [N-1:0] w_mask_nxt;
    logic [N-1:0] w_mode_nxt;
    logic [N-1:0] w_active;
    logic [3:0]   w_vec_idx;
    logic         w_vec_valid;
    logic [15:0]  w_pend_ext;
    logic [15:0]  w_mask_ext;
    logic [15:0]  w_raw_ext;
    logic [15:0]  w_mode_ext;
    logic [15:0]  w_vector;
    logic [15:0]  w_rd_mux;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[N-1:0];

    always_comb begin
        w_clr = '0;
        w_frc = '0;
        if (w_wr && (address == ADDR_PENDING)) begin
            w_clr = w_wdata;
        end
        if (w_wr && (address == ADDR_FORCE)) begin
            w_frc = w_wdata;
        end
    end

    assign w_event = irq_in & ~r_irq_prev;

    // Setting always wins over a same-cycle clear so no event is lost.
    assign w_forced_nxt = w_frc | (r_forced & ~w_clr);
    assign w_pend_edge  = w_event | w_frc | (r_pending & ~w_clr);
    assign w_pend_level = irq_in | w_forced_nxt;
    assign w_pend_nxt   = (r_mode & w_pend_edge) | (~r_mode & w_pend_level);

    assign w_mask_nxt = (w_wr && (address == ADDR_MASK)) ? w_wdata : r_mask;
    assign w_mode_nxt = (w_wr && (address == ADDR_MODE)) ? w_wdata : r_mode;

    assign w_active = r_pending & r_mask;

    // Lowest-numbered active source wins.
    always_comb begin
        w_vec_idx   = 4'd0;
        w_vec_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx   = 4'(i);
                w_vec_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_pend_ext            = '0;
        w_mask_ext            = '0;
        w_raw_ext             = '0;
        w_mode_ext            = '0;
        w_pend_ext[N-1:0]     = r_pending;
        w_mask_ext[N-1:0]     = r_mask;
        w_raw_ext[N-1:0]      = irq_in;
        w_mode_ext[N-1:0]     = r_mode;
    end

    assign w_vector = w_vec_valid ? {1'b1, 11'd0, w_vec_idx} : 16'h0000;

    always_comb begin
        w_rd_mux = 16'h0000;
        case (address)
            ADDR_PENDING: w_rd_mux = w_pend_ext;
            ADDR_MASK:    w_rd_mux = w_mask_ext;
            ADDR_RAW:     w_rd_mux = w_raw_ext;
            ADDR_VECTOR:  w_rd_mux = w_vector;
            ADDR_MODE:    w_rd_mux = w_mode_ext;
            default:      w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_forced   <= '0;
            r_mask     <= '0;
            r_mode     <= EDGE_DEFAULT[N-1:0];
            r_irq_prev <= '0;
            r_readdata <= 16'h0000;
            r_irq_out  <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_forced   <= w_forced_nxt;
            r_mask     <= w_mask_nxt;
            r_mode     <= w_mode_nxt;
            r_irq_prev <= irq_in;
            r_readdata <= w_rd_mux;
            r_irq_out  <= |w_active;
        end
    end

    assign readdata = r_readdata;
    assign irq_out  = r_irq_out;

endmodule

// File: tb/tb_niosii_subsys_irq_aggregator.sv
// Bench for niosii_subsys_irq_aggregator: directed scenarios, then random traffic
// checked cycle by cycle against a per-bit behavioural model.
module tb_niosii_subsys_irq_aggregator;

    localparam int N = 8;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [15:0]  writedata;
    logic [15:0]  readdata;
    logic [N-1:0] irq_in;
    logic         irq_out;

    int errors;
    int checks;

    // Model state
    logic [N-1:0] m_pend;
    logic [N-1:0] m_forced;
    logic [N-1:0] m_mask;
    logic [N-1:0] m_mode;
    logic [N-1:0] m_prev;

    niosii_subsys_irq_aggregator #(
        .NUM_IRQ      (N),
        .EDGE_DEFAULT (16'hFFFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks enter and leave on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        check(tag, readdata, exp);
    endtask

    function automatic logic [15:0] model_vector(input logic [N-1:0] act);
        for (int i = 0; i < N; i++) begin
            if (act[i]) return 16'h8000 | 16'(i);
        end
        return 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a, input logic [N-1:0] raw);
        case (a)
            3'd0:    return 16'(m_pend);
            3'd1:    return 16'(m_mask);
            3'd2:    return 16'(raw);
            3'd3:    return model_vector(m_pend & m_mask);
            3'd4:    return 16'(m_mode);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pend   = '0;
        m_forced = '0;
        m_mask   = '0;
        m_mode   = 8'hFF;
        m_prev   = '0;
    endtask

    // One clock of behaviour, applied bit by bit from the register-level rules.
    task automatic model_step(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [15:0] d, input logic [N-1:0] raw);
        bit we;
        bit ev;
        bit clr;
        bit frc;
        we = cs && !wn;
        for (int i = 0; i < N; i++) begin
            ev  = raw[i] && !m_prev[i];
            clr = we && (a == 3'd0) && d[i];
            frc = we && (a == 3'd5) && d[i];
            m_forced[i] = frc || (m_forced[i] && !clr);
            if (m_mode[i]) m_pend[i] = ev || frc || (m_pend[i] && !clr);
            else           m_pend[i] = raw[i] || m_forced[i];
        end
        if (we && a == 3'd1) m_mask = d[N-1:0];
        if (we && a == 3'd4) m_mode = d[N-1:0];
        m_prev = raw;
    endtask

    initial begin
        logic [15:0] exp_rd;
        logic        exp_irq;
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = '0;
        repeat (2) @(negedge clk);
        check("reset_rd", readdata, 16'h0000);
        check("reset_irq", 16'(irq_out), 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values and single edge on source 0
        rd_check("mask_reset", 3'd1, 16'h0000);
        rd_check("mode_reset", 3'd4, 16'h00FF);
        rd_check("pend_reset", 3'd0, 16'h0000);
        wr(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        check("t1_irq_lat", 16'(irq_out), 16'h0000);
        @(negedge clk);
        check("t1_irq_set", 16'(irq_out), 16'h0001);
        rd_check("t1_pend", 3'd0, 16'h0001);
        rd_check("t1_vec", 3'd3, 16'h8000);

        // Two simultaneous edges, then clear one at a time
        wr(3'd1, 16'h0028);
        irq_in[3] = 1'b1;
        irq_in[5] = 1'b1;
        @(negedge clk);
        irq_in = '0;
        rd_check("t2_vec3", 3'd3, 16'h8003);
        wr(3'd0, 16'h0008);
        rd_check("t2_vec5", 3'd3, 16'h8005);
        wr(3'd0, 16'h0020);
        check("t2_irq_hold", 16'(irq_out), 16'h0001);
        @(negedge clk);
        check("t2_irq_clr", 16'(irq_out), 16'h0000);
        rd_check("t2_vec0", 3'd3, 16'h0000);

        // Clear colliding with a new edge
        irq_in[2] = 1'b1;
        wr(3'd0, 16'h0004);
        irq_in[2] = 1'b0;
        rd_check("t3_set_wins", 3'd0, 16'h0005);
        wr(3'd0, 16'h00FF);
        rd_check("t3_cleared", 3'd0, 16'h0000);

        // Level mode
        wr(3'd4, 16'h0000);
        irq_in[1] = 1'b1;
        @(negedge clk);
        wr(3'd0, 16'h0002);
        rd_check("t4_level_hold", 3'd0, 16'h0002);
        irq_in[1] = 1'b0;
        @(negedge clk);
        rd_check("t4_level_drop", 3'd0, 16'h0000);

        // FORCE with mask off, then on
        wr(3'd1, 16'h0000);
        wr(3'd5, 16'h0040);
        rd_check("t5_forced", 3'd0, 16'h0040);
        check("t5_irq_masked", 16'(irq_out), 16'h0000);
        wr(3'd1, 16'h0040);
        check("t5_irq_lat", 16'(irq_out), 16'h0000);
        @(negedge clk);
        check("t5_irq_set", 16'(irq_out), 16'h0001);
        rd_check("t5_force_rd", 3'd5, 16'h0000);

        // Asynchronous reset mid-operation
        wr(3'd1, 16'h00FF);
        wr(3'd5, 16'h00FF);
        rd_check("t6_pend_ff", 3'd0, 16'h00FF);
        check("t6_irq_pre", 16'(irq_out), 16'h0001);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rd_async", readdata, 16'h0000);
        check("t6_irq_async", 16'(irq_out), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_check("t6_pend_rst", 3'd0, 16'h0000);
        rd_check("t6_mask_rst", 3'd1, 16'h0000);

        // Random traffic against the model, from a fresh reset
        reset_n = 1'b0;
        irq_in  = '0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            irq_in     = irq_in ^ N'($urandom & $urandom & $urandom);
            chipselect = ($urandom % 4) != 0;
            write_n    = ($urandom % 3) != 0;
            address    = 3'($urandom);
            writedata  = 16'($urandom & $urandom);
            exp_rd  = model_read(address, irq_in);
            exp_irq = |(m_pend & m_mask);
            model_step(chipselect, write_n, address, writedata, irq_in);
            @(negedge clk);
            check("rnd_rd", readdata, exp_rd);
            check("rnd_irq", 16'(irq_out), 16'(exp_irq));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
